// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: fetch PC generation, 1-cycle BRAM read port, FQ_DEPTH-entry prefetch queue.
// Optional FETCH_BYTE_ADDR_EN: byte-addressed PCs (step 4, word-aligned redirect); default is word-addressed PCs.
module if_prefetch_unit #(
  parameter int unsigned            XLEN     = 32,
  parameter int unsigned            IMEM_AW  = 10,
  parameter int unsigned            FQ_DEPTH = 4,
  parameter logic [XLEN-1:0]        RESET_PC = '0
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               redirect_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  output logic               imem_en_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  input  logic [XLEN-1:0]    imem_rdata_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [XLEN-1:0]    out_instr_o,
  output logic [XLEN-1:0]    out_pc_o
);

  localparam int unsigned PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);

`ifdef FETCH_BYTE_ADDR_EN
  localparam logic [XLEN-1:0] INC = XLEN'(4);
`else
  localparam logic [XLEN-1:0] INC = XLEN'(1);
`endif

  logic [XLEN-1:0] fetch_pc_q,   fetch_pc_d;
  logic            pending_q,    pending_d;
  logic [XLEN-1:0] pending_pc_q, pending_pc_d;
  logic [PW-1:0]   rd_ptr_q,     rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q,     wr_ptr_d;
  logic [CW-1:0]   count_q,      count_d;
  logic [XLEN-1:0] instr_q [FQ_DEPTH];
  logic [XLEN-1:0] pc_q    [FQ_DEPTH];

  logic            pop;
  logic            push;
  logic            issue;
  logic [CW:0]     used;
  logic [CW:0]     limit;
  logic [XLEN-1:0] redirect_tgt;

`ifdef FETCH_BYTE_ADDR_EN
  assign redirect_tgt = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign imem_addr_o  = fetch_pc_q[IMEM_AW+1:2];
`else
  assign redirect_tgt = redirect_pc_i;
  assign imem_addr_o  = fetch_pc_q[IMEM_AW-1:0];
`endif

  assign out_valid_o = reset_i && (count_q != '0);
  assign out_instr_o = reset_i ? instr_q[rd_ptr_q] : '0;
  assign out_pc_o    = reset_i ? pc_q[rd_ptr_q]    : '0;

  assign pop  = out_valid_o && out_ready_i;
  assign push = pending_q && !redirect_i;

  // Credit rule: every queued entry plus the in-flight read owns a slot; a pop this cycle frees one.
  assign used      = {1'b0, count_q} + {{CW{1'b0}}, pending_q};
  assign limit     = (CW+1)'(FQ_DEPTH) + {{CW{1'b0}}, pop};
  assign issue     = reset_i && !redirect_i && (used < limit);
  assign imem_en_o = issue;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pending_d    = pending_q;
    pending_pc_d = pending_pc_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    if (redirect_i) begin
      fetch_pc_d = redirect_tgt;
      pending_d  = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      pending_d = issue;
      if (issue) begin
        pending_pc_d = fetch_pc_q;
        fetch_pc_d   = fetch_pc_q + INC;
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      fetch_pc_q   <= RESET_PC;
      pending_q    <= 1'b0;
      pending_pc_q <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      for (int i = 0; i < int'(FQ_DEPTH); i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (push) begin
      instr_q[wr_ptr_q] <= imem_rdata_i;
      pc_q[wr_ptr_q]    <= pending_pc_q;
    end
  end

  // A return must never land on a full queue that is not draining this cycle.
  a_no_overflow: assert property (@(posedge clock_i) disable iff (!reset_i)
    !(push && !pop && (count_q == CW'(FQ_DEPTH))));

endmodule
